mmss_timer_ctrl: RTL and testbench

MMSS_TIMER_CTRL -- requirements
Module: mmss_timer_ctrl

---
 rtl/mmss_timer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mmss_timer_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmss_timer_ctrl.sv
// mm:ss BCD countdown timer: prescaled one-second tick, pause/resume,
// validated load and a timed alarm phase before returning to idle.
//
// state | meaning
// IDLE  | stopped, q holds last value, prescaler cleared
// RUN   | counting down once per tick
// PAUSE | frozen, prescaler keeps its phase for resume
// ALARM | reached 00:00, alarm held for ALARM_TICKS ticks
module mmss_timer_ctrl #(
   parameter int TICK_DIV    = 50000000,
   parameter int ALARM_TICKS = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       load,
   input  logic [3:0] ld_q1,
   input  logic [3:0] ld_q2,
   input  logic [3:0] ld_q3,
   input  logic [3:0] ld_q4,
   output logic [3:0] q1,
   output logic [3:0] q2,
   output logic [3:0] q3,
   output logic [3:0] q4,
   output logic [1:0] state,
   output logic       running,
   output logic       alarm,
   output logic       load_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, ALARM = 2'd3} state_t;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW = $clog2(ALARM_TICKS + 1);
   localparam logic [PW-1:0] PRE_TC = PW'(TICK_DIV - 1);
   localparam logic [AW-1:0] ATK_TC = AW'(ALARM_TICKS - 1);

   state_t        st_q, st_d;
   logic [15:0]   q_q, q_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [AW-1:0] atk_q, atk_d;
   logic          err_d;
   logic          tick, ld_ok, ld_ok_state;
   logic [15:0]   ld_val;

   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (v[3:0] != 4'd0) begin
         r[3:0] = v[3:0] - 4'd1;
      end else begin
         r[3:0] = 4'd9;
         if (v[7:4] != 4'd0) begin
            r[7:4] = v[7:4] - 4'd1;
         end else begin
            r[7:4] = 4'd5;
            if (v[11:8] != 4'd0) begin
               r[11:8] = v[11:8] - 4'd1;
            end else begin
               r[11:8]  = 4'd9;
               r[15:12] = v[15:12] - 4'd1;
            end
         end
      end
      return r;
   endfunction

   assign tick        = ((st_q == RUN) || (st_q == ALARM)) && (pre_q == PRE_TC);
   assign ld_val      = {ld_q1, ld_q2, ld_q3, ld_q4};
   assign ld_ok       = (ld_q1 <= 4'd5) && (ld_q2 <= 4'd9) && (ld_q3 <= 4'd5) && (ld_q4 <= 4'd9);
   assign ld_ok_state = (st_q == IDLE) || (st_q == PAUSE);

   always_comb begin
      st_d  = st_q;
      q_d   = q_q;
      pre_d = pre_q;
      atk_d = atk_q;
      err_d = 1'b0;
      if (ld_ok_state && load && ld_ok) begin
         q_d   = ld_val;
         st_d  = IDLE;
         pre_d = '0;
      end else begin
         err_d = ld_ok_state && load;
         case (st_q)
            IDLE: begin
               if (start && !stop && (q_q != 16'h0000)) begin
                  st_d  = RUN;
                  pre_d = '0;
               end
            end
            RUN: begin
               // stop freezes the prescaler phase so resume lands on the same sub-second offset
               if (stop) begin
                  st_d = PAUSE;
               end else begin
                  pre_d = tick ? '0 : pre_q + PW'(1);
                  if (tick) begin
                     if (q_q == 16'h0001) begin
                        q_d   = 16'h0000;
                        st_d  = ALARM;
                        atk_d = '0;
                     end else begin
                        q_d = bcd_dec(q_q);
                     end
                  end
               end
            end
            PAUSE: begin
               if (stop) begin
                  st_d  = IDLE;
                  pre_d = '0;
               end else if (start) begin
                  st_d = RUN;
               end
            end
            ALARM: begin
               if (stop) begin
                  st_d  = IDLE;
                  pre_d = '0;
                  atk_d = '0;
               end else begin
                  pre_d = tick ? '0 : pre_q + PW'(1);
                  if (tick) begin
                     if (atk_q == ATK_TC) begin
                        st_d  = IDLE;
                        pre_d = '0;
                        atk_d = '0;
                     end else begin
                        atk_d = atk_q + AW'(1);
                     end
                  end
               end
            end
            default: st_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st_q     <= IDLE;
         q_q      <= '0;
         pre_q    <= '0;
         atk_q    <= '0;
         running  <= 1'b0;
         alarm    <= 1'b0;
         load_err <= 1'b0;
      end else begin
         st_q     <= st_d;
         q_q      <= q_d;
         pre_q    <= pre_d;
         atk_q    <= atk_d;
         running  <= (st_d == RUN);
         alarm    <= (st_d == ALARM);
         load_err <= err_d;
      end
   end

   assign state = st_q;
   assign q1    = q_q[15:12];
   assign q2    = q_q[11:8];
   assign q3    = q_q[7:4];
   assign q4    = q_q[3:0];

endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// Bench for mmss_timer_ctrl: seconds-based reference model compared every
// cycle, directed scenarios with literal expectations, then random commands.
module tb_mmss_timer_ctrl;
   localparam int TICK_DIV    = 4;
   localparam int ALARM_TICKS = 2;

   logic       clock, reset;
   logic       start, stop, load;
   logic [3:0] ld_q1, ld_q2, ld_q3, ld_q4;
   logic [3:0] q1, q2, q3, q4;
   logic [1:0] state;
   logic       running, alarm, load_err;

   int errors = 0;
   int checks = 0;

   mmss_timer_ctrl #(.TICK_DIV(TICK_DIV), .ALARM_TICKS(ALARM_TICKS)) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .load(load),
      .ld_q1(ld_q1), .ld_q2(ld_q2), .ld_q3(ld_q3), .ld_q4(ld_q4),
      .q1(q1), .q2(q2), .q3(q3), .q4(q4), .state(state),
      .running(running), .alarm(alarm), .load_err(load_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time kept as total seconds, phase as an integer modulo TICK_DIV
   int m_st = 0, m_t = 0, m_pre = 0, m_atk = 0;
   bit m_err = 1'b0;
   bit m_valid, m_tk, m_idle_or_pause;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_st = 0; m_t = 0; m_pre = 0; m_atk = 0; m_err = 1'b0;
      end else begin
         m_valid = (ld_q1 <= 5) && (ld_q2 <= 9) && (ld_q3 <= 5) && (ld_q4 <= 9);
         m_tk = ((m_st == 1) || (m_st == 3)) && (m_pre == TICK_DIV - 1);
         m_idle_or_pause = (m_st == 0) || (m_st == 2);
         m_err = 1'b0;
         if (m_idle_or_pause && load && m_valid) begin
            m_t = (int'(ld_q1) * 10 + int'(ld_q2)) * 60 + int'(ld_q3) * 10 + int'(ld_q4);
            m_st = 0; m_pre = 0;
         end else begin
            if (m_idle_or_pause && load) m_err = 1'b1;
            case (m_st)
               0: if (start && !stop && m_t != 0) begin m_st = 1; m_pre = 0; end
               1: if (stop) m_st = 2;
                  else begin
                     m_pre = (m_pre + 1) % TICK_DIV;
                     if (m_tk) begin
                        m_t = m_t - 1;
                        if (m_t == 0) begin m_st = 3; m_atk = 0; end
                     end
                  end
               2: if (stop) begin m_st = 0; m_pre = 0; end
                  else if (start) m_st = 1;
               default: if (stop) begin m_st = 0; m_pre = 0; m_atk = 0; end
                  else begin
                     m_pre = (m_pre + 1) % TICK_DIV;
                     if (m_tk) begin
                        m_atk = m_atk + 1;
                        if (m_atk == ALARM_TICKS) begin m_st = 0; m_pre = 0; m_atk = 0; end
                     end
                  end
            endcase
         end
      end
   end

   logic [15:0] exp_q;
   int mm, ss;
   always @(negedge clock) begin
      mm = m_t / 60;
      ss = m_t % 60;
      exp_q = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
      chk("model_q", {16'h0, q1, q2, q3, q4}, {16'h0, exp_q});
      chk("model_state", {30'h0, state}, 32'(m_st));
      chk("model_running", {31'h0, running}, {31'h0, m_st == 1});
      chk("model_alarm", {31'h0, alarm}, {31'h0, m_st == 3});
      chk("model_load_err", {31'h0, load_err}, {31'h0, m_err});
   end

   task automatic drive(input bit st, input bit sp, input bit ld, input logic [15:0] v);
      @(negedge clock);
      start = st; stop = sp; load = ld;
      {ld_q1, ld_q2, ld_q3, ld_q4} = v;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic do_load(input logic [15:0] v);
      drive(1'b0, 1'b0, 1'b1, v);
   endtask

   function automatic logic [31:0] qv();
      return {16'h0, q1, q2, q3, q4};
   endfunction

   int acnt;
   bit r_st, r_sp, r_ld;
   logic [15:0] r_v;

   initial begin
      start = 0; stop = 0; load = 0;
      ld_q1 = 0; ld_q2 = 0; ld_q3 = 0; ld_q4 = 0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #11 reset = 1'b0;

      chk("reset_q", qv(), 32'h0);
      chk("reset_state", {30'h0, state}, 32'd0);

      // countdown 00:03 into alarm and back to idle
      do_load(16'h0003);
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      idle(5);
      chk("run_q_0002", qv(), 32'h0002);
      chk("run_running", {31'h0, running}, 32'd1);
      idle(4);
      chk("run_q_0001", qv(), 32'h0001);
      idle(4);
      chk("alarm_q_0000", qv(), 32'h0000);
      chk("alarm_state", {30'h0, state}, 32'd3);
      acnt = 1;
      for (int k = 0; k < 12; k++) begin
         idle(1);
         if (alarm) acnt++;
      end
      chk("alarm_len", 32'(acnt), 32'd8);
      chk("alarm_end_state", {30'h0, state}, 32'd0);

      // borrow chains
      do_load(16'h1000);
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      idle(5);
      chk("borrow_0959", qv(), 32'h0959);
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      idle(1);
      chk("pause_state", {30'h0, state}, 32'd2);
      do_load(16'h0600);
      idle(1);
      chk("load_in_pause", qv(), 32'h0600);
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      idle(5);
      chk("borrow_0559", qv(), 32'h0559);

      // invalid load, then load ignored while running
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      do_load(16'h0760);
      idle(1);
      chk("bad_load_err", {31'h0, load_err}, 32'd1);
      chk("bad_load_q", qv(), 32'h0559);
      idle(1);
      chk("bad_load_pulse", {31'h0, load_err}, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      idle(2);
      do_load(16'h0100);
      idle(1);
      chk("run_load_noerr", {31'h0, load_err}, 32'd0);
      chk("run_load_q", qv(), 32'h0559);
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      drive(1'b0, 1'b1, 1'b0, 16'h0);

      // pause keeps prescaler phase
      do_load(16'h0009);
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      idle(2);
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      idle(4);
      chk("pause_frozen_q", qv(), 32'h0009);
      chk("pause_frozen_st", {30'h0, state}, 32'd2);
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      idle(2);
      chk("resume_before", qv(), 32'h0009);
      idle(1);
      chk("resume_dec", qv(), 32'h0008);
      drive(1'b1, 1'b1, 1'b0, 16'h0);
      idle(1);
      chk("start_stop_pause", {30'h0, state}, 32'd2);
      drive(1'b0, 1'b1, 1'b0, 16'h0);

      // start at zero ignored; stop in alarm
      do_load(16'h0000);
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      idle(1);
      chk("zero_start", {30'h0, state}, 32'd0);
      do_load(16'h0001);
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      idle(5);
      chk("to_alarm", {30'h0, state}, 32'd3);
      drive(1'b0, 1'b1, 1'b0, 16'h0);
      idle(1);
      chk("alarm_stop_st", {30'h0, state}, 32'd0);
      chk("alarm_stop_al", {31'h0, alarm}, 32'd0);

      // reset mid-run
      do_load(16'h0328);
      drive(1'b1, 1'b0, 1'b0, 16'h0);
      idle(5);
      chk("pre_reset_q", qv(), 32'h0327);
      #2 reset = 1'b1;
      #1;
      chk("rst_q", qv(), 32'h0);
      chk("rst_outs", {28'h0, state, running, alarm}, 32'h0);
      #1 reset = 1'b0;
      idle(10);
      chk("post_rst_q", qv(), 32'h0);
      chk("post_rst_state", {30'h0, state}, 32'd0);

      // random commands against the model
      for (int i = 0; i < 3000; i++) begin
         r_st = ($urandom_range(0, 7) == 0);
         r_sp = ($urandom_range(0, 15) == 0);
         r_ld = ($urandom_range(0, 19) == 0);
         r_v[15:12] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 6)) : 4'd0;
         r_v[11:8]  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 10)) : 4'd0;
         r_v[7:4]   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 6)) : 4'd0;
         r_v[3:0]   = 4'($urandom_range(0, 10));
         drive(r_st, r_sp, r_ld, r_v);
         if ($urandom_range(0, 399) == 0) begin
            #2 reset = 1'b1;
            #2 reset = 1'b0;
         end
      end
      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
